instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch stage sitting directly downstream of the n-bit program counter.
//  Reads the PC value and fetches a 2-byte instruction (opcode, operand) from byte-wide memory via a req/ack handshake.
//  Drives the PC's 2-bit ctrl and parallel-load inputs; presents the instruction register to execute with a valid/ready handshake.
// PARAMETERS
//  AW  8  address width; equals PC width n
//  DW  8  memory data / opcode / operand width
// PORTS
//  clk         in   1   rising-edge clock
//  clr         in   1   reset: synchronous, active-high
//  fetch_en    in   1   1 = run fetch loop; 0 = stop at next instruction boundary
//  pc_val      in   AW  current PC (PC pc_out)
//  pc_ctrl     out  2   to PC ctrl: 00 hold, 01 load, 10 +1, 11 +inc (11 never driven)
//  pc_load     out  AW  to PC pc_in; = br_target, else 0
//  mem_req     out  1   memory read request
//  mem_addr    out  AW  read address; = pc_val combinationally
//  mem_ack     in   1   read data valid this cycle
//  mem_rdata   in   DW  read data
//  ir_opcode   out  DW  registered opcode
//  ir_operand  out  DW  registered operand
//  ir_valid    out  1   instruction available
//  ir_ready    in   1   execute accepts the instruction
//  br_take     in   1   branch taken; sampled only on ir_valid&&ir_ready
//  br_target   in   AW  branch target
// BEHAVIOUR
//  - FSM states: IDLE, F_OP, F_ARG, HOLD.
//  - Outputs: pc_ctrl, pc_load, mem_req and mem_addr are combinational from state and inputs. ir_* are registered.
//  - clr=1 at an edge: state<=IDLE, ir_opcode<=0, ir_operand<=0, ir_valid<=0. Overrides all other events, including mid-fetch and mid-HOLD.
//    Any outstanding memory ack is then ignored. The PC is cleared by its own clear, not by this block.
//  - IDLE: mem_req=0, pc_ctrl=00. If fetch_en, go to F_OP.
//  - F_OP: mem_req=1.
//    - No ack: pc_ctrl=00, stay.
//    - On mem_ack: ir_opcode<=mem_rdata, pc_ctrl=10 (the PC advances at the same edge), go to F_ARG.
//  - F_ARG: mem_req=1 with mem_addr=pc_val (old PC+1).
//    - On mem_ack: ir_operand<=mem_rdata, pc_ctrl=10, ir_valid<=1, go to HOLD.
//  - HOLD: mem_req=0, ir_valid=1, ir_* stable.
//    - ir_ready=0: pc_ctrl=00, stay.
//    - ir_ready=1 and br_take=1: pc_ctrl=01, pc_load=br_target.
//    - ir_ready=1 and br_take=0: pc_ctrl=00.
//    - Either accept case: ir_valid<=0, next state F_OP if fetch_en, else IDLE.
//  - Latencies:
//    - With 0-wait memory (ack in the same cycle as req), one instruction every 3 cycles when ir_ready is held high.
//    - First mem_req is asserted 1 cycle after fetch_en rises.
//  - mem_req stays high and mem_addr stays stable until ack; mem_ack outside F_OP/F_ARG is ignored.
//  - fetch_en dropping during F_OP/F_ARG does not abort the fetch; the block completes to HOLD and stops after acceptance.
//  - Address wrap: the PC wraps 2^AW-1 -> 0 between the opcode and operand fetch; no special handling here.
//  - Simultaneous mem_ack and ir_ready cannot occur, since they are serviced in disjoint states.
//  - The PC +inc code (11) is never issued; the PC advances by two +1 steps per instruction.
// STRUCTURE
//  - Shared package (cpu_pkg): PC ctrl codes PC_HOLD=2'b00, PC_LOAD=2'b01, PC_INC1=2'b10, PC_INCN=2'b11, and this block's FSM state encodings.
//  - One sub-module: ir_reg, a pair of DW-bit registers with separate load enables and a synchronous clear. Holds opcode and operand.
//  - The FSM and output decode are in the top level.
// TESTING
//  1. clr=1 for 2 cycles mid-F_ARG, then clr=0 -> state IDLE, ir_valid=0, ir_opcode=ir_operand=0, pc_ctrl=00, mem_req=0.
//  2. fetch_en=1, pc_val=0x10, 0-wait memory returning 0xA5, 0x3C, ir_ready=1 ->
//     req addr 0x10 then 0x11, pc_ctrl=10 on each ack, ir_opcode=0xA5, ir_operand=0x3C, new fetch at 0x12.
//  3. Memory inserts 3 wait cycles on the opcode ->
//     mem_req high and mem_addr=0x10 held for 4 cycles, pc_ctrl=00 until ack.
//  4. ir_ready=0 for 5 cycles in HOLD -> ir_valid=1 and ir_* unchanged, no mem_req, pc_ctrl=00.
//  5. Accept with br_take=1, br_target=0x80 -> pc_ctrl=01, pc_load=0x80 for 1 cycle, next fetch address 0x80.
//  6. pc_val=0xFF -> opcode from 0xFF, operand from 0x00.
//     Drop fetch_en mid-F_OP -> instruction completes, then IDLE after accept.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter control codes and instruction-fetch FSM encodings.
package cpu_pkg;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_LOAD = 2'b01;
    localparam logic [1:0] PC_INC1 = 2'b10;
    localparam logic [1:0] PC_INCN = 2'b11;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_F_OP  = 2'b01,
        IF_F_ARG = 2'b10,
        IF_HOLD  = 2'b11
    } if_state_t;

endpackage

// File: rtl/instr_fetch_ir_reg.sv
// Instruction register: opcode and operand bytes with independent load enables and a synchronous clear.
module ir_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_ld_op,
    input  logic          i_ld_arg,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_opcode,
    output logic [DW-1:0] o_operand
);

    logic [DW-1:0] r_opcode;
    logic [DW-1:0] r_operand;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_opcode  <= '0;
            r_operand <= '0;
        end else begin
            if (i_ld_op)
                r_opcode <= i_din;
            if (i_ld_arg)
                r_operand <= i_din;
        end
    end

    assign o_opcode  = r_opcode;
    assign o_operand = r_operand;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: reads opcode and operand bytes at the PC, steers the PC and
// hands the assembled instruction to execute over a valid/ready handshake.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          fetch_en,
    input  logic [AW-1:0] pc_val,
    output logic [1:0]    pc_ctrl,
    output logic [AW-1:0] pc_load,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir_opcode,
    output logic [DW-1:0] ir_operand,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          br_take,
    input  logic [AW-1:0] br_target
);

    if_state_t r_state;
    if_state_t w_next;
    logic      r_ir_valid;
    logic      w_ld_op;
    logic      w_ld_arg;
    logic      w_accept;

    assign w_accept = (r_state == IF_HOLD) && ir_ready;

    always_ff @(posedge clk) begin
        if (clr)
            r_state <= IF_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IF_IDLE:  if (fetch_en) w_next = IF_F_OP;
            IF_F_OP:  if (mem_ack)  w_next = IF_F_ARG;
            IF_F_ARG: if (mem_ack)  w_next = IF_HOLD;
            IF_HOLD:  if (ir_ready) w_next = fetch_en ? IF_F_OP : IF_IDLE;
            default:  w_next = IF_IDLE;
        endcase
    end

    // Each acknowledged byte bumps the PC, so the operand is always read from the old PC+1.
    always_comb begin
        mem_req  = 1'b0;
        pc_ctrl  = PC_HOLD;
        pc_load  = '0;
        w_ld_op  = 1'b0;
        w_ld_arg = 1'b0;
        case (r_state)
            IF_F_OP: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_ctrl = PC_INC1;
                    w_ld_op = 1'b1;
                end
            end
            IF_F_ARG: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_ctrl  = PC_INC1;
                    w_ld_arg = 1'b1;
                end
            end
            IF_HOLD: begin
                if (w_accept && br_take) begin
                    pc_ctrl = PC_LOAD;
                    pc_load = br_target;
                end
            end
            default: ;
        endcase
    end

    assign mem_addr = pc_val;

    always_ff @(posedge clk) begin
        if (clr)
            r_ir_valid <= 1'b0;
        else if (w_ld_arg)
            r_ir_valid <= 1'b1;
        else if (w_accept)
            r_ir_valid <= 1'b0;
    end

    assign ir_valid = r_ir_valid;

    ir_reg #(.DW(DW)) u_ir_reg (
        .clk       (clk),
        .clr       (clr),
        .i_ld_op   (w_ld_op),
        .i_ld_arg  (w_ld_arg),
        .i_din     (mem_rdata),
        .o_opcode  (ir_opcode),
        .o_operand (ir_operand)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC and byte-memory models around the DUT, with scoreboard
// monitors for memory fetches and accepted instructions plus directed cycle checks.
module tb_instr_fetch;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          fetch_en;
    logic [AW-1:0] pc_val = '0;
    logic [1:0]    pc_ctrl;
    logic [AW-1:0] pc_load;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] ir_opcode;
    logic [DW-1:0] ir_operand;
    logic          ir_valid;
    logic          ir_ready;
    logic          br_take;
    logic [AW-1:0] br_target;

    logic          pc_wr;
    logic [AW-1:0] pc_wdata;
    logic [DW-1:0] mem [256];
    logic [8:0]    wait_addr;
    int            wcnt = 0;

    typedef struct packed {
        logic [DW-1:0] op;
        logic [DW-1:0] arg;
    } instr_t;

    instr_t        exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            total = 0;
    int            bad = 0;

    instr_fetch #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .clr        (clr),
        .fetch_en   (fetch_en),
        .pc_val     (pc_val),
        .pc_ctrl    (pc_ctrl),
        .pc_load    (pc_load),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .br_take    (br_take),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    // Program counter model driven by the DUT's ctrl/load outputs
    always @(posedge clk) begin
        if (pc_wr)
            pc_val <= pc_wdata;
        else if (pc_ctrl == 2'b01)
            pc_val <= pc_load;
        else if (pc_ctrl == 2'b10)
            pc_val <= pc_val + 8'd1;
    end

    // Memory: zero-wait except at wait_addr, where the ack comes after 3 wait cycles
    always_comb begin
        mem_ack   = mem_req && (({1'b0, mem_addr} != wait_addr) || (wcnt == 3));
        mem_rdata = mem_ack ? mem[mem_addr] : '0;
    end

    always @(posedge clk)
        wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon_fetch
        logic [AW-1:0] a;
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            if (addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_fetch: got addr 0x%0h expected none at %0t", mem_addr, $time);
            end else begin
                a = addr_q.pop_front();
                chk("fetch_addr", 32'(mem_addr), 32'(a));
                chk("ack_pc_ctrl", 32'(pc_ctrl), 32'(2'b10));
            end
        end
    end

    always @(negedge clk) begin : mon_ir
        instr_t e;
        if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept: got op 0x%0h arg 0x%0h expected none", ir_opcode, ir_operand);
            end else begin
                e = exp_q.pop_front();
                chk("ir_opcode", 32'(ir_opcode), 32'(e.op));
                chk("ir_operand", 32'(ir_operand), 32'(e.arg));
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pc(input logic [AW-1:0] v);
        pc_wr    = 1'b1;
        pc_wdata = v;
        adv(1);
        pc_wr    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C;
        mem[8'h12] = 8'h77; mem[8'h13] = 8'h88;
        mem[8'h80] = 8'h5A; mem[8'h81] = 8'hC3;
        mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22;

        clr = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0; br_take = 1'b0;
        br_target = '0; pc_wr = 1'b0; pc_wdata = '0; wait_addr = 9'h100;
        adv(2);
        clr = 1'b0;
        @(negedge clk);
        chk("rst_ir_valid", 32'(ir_valid), 32'(0));
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_pc_ctrl", 32'(pc_ctrl), 32'(0));
        chk("rst_opcode", 32'(ir_opcode), 32'(0));
        adv(1);

        // clear asserted for two cycles while the operand read is stalled
        set_pc(8'h10);
        fetch_en = 1'b1; wait_addr = 9'h011;
        addr_q.push_back(8'h10);
        adv(2);
        clr = 1'b1; fetch_en = 1'b0;
        @(negedge clk);
        chk("t1_opcode_before_clr", 32'(ir_opcode), 32'(8'hA5));
        chk("t1_in_arg_addr", 32'(mem_addr), 32'(8'h11));
        adv(2);
        clr = 1'b0; wait_addr = 9'h100;
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req), 32'(0));
        chk("t1_pc_ctrl", 32'(pc_ctrl), 32'(0));
        chk("t1_ir_valid", 32'(ir_valid), 32'(0));
        chk("t1_opcode", 32'(ir_opcode), 32'(0));
        chk("t1_operand", 32'(ir_operand), 32'(0));
        adv(1);
        @(negedge clk);
        chk("t1_idle_stays", 32'(mem_req), 32'(0));
        adv(1);

        // zero-wait back-to-back fetch, fetch_en dropped during the second opcode
        set_pc(8'h10);
        fetch_en = 1'b1; ir_ready = 1'b1;
        addr_q.push_back(8'h10); addr_q.push_back(8'h11);
        addr_q.push_back(8'h12); addr_q.push_back(8'h13);
        exp_q.push_back('{op: 8'hA5, arg: 8'h3C});
        exp_q.push_back('{op: 8'h77, arg: 8'h88});
        @(negedge clk);
        chk("t2_no_req_yet", 32'(mem_req), 32'(0));
        adv(1);
        @(negedge clk);
        chk("t2_first_req", 32'(mem_req), 32'(1));
        adv(2);
        @(negedge clk);
        chk("t2_hold_valid", 32'(ir_valid), 32'(1));
        chk("t2_hold_req", 32'(mem_req), 32'(0));
        chk("t2_accept_ctrl", 32'(pc_ctrl), 32'(2'b00));
        adv(1);
        fetch_en = 1'b0;
        @(negedge clk);
        chk("t2_next_addr", 32'(mem_addr), 32'(8'h12));
        chk("t2_next_req", 32'(mem_req), 32'(1));
        adv(3);
        @(negedge clk);
        chk("t2_idle_req", 32'(mem_req), 32'(0));
        chk("t2_idle_valid", 32'(ir_valid), 32'(0));
        adv(1);

        // opcode wait states, stall in HOLD, then branch on accept
        set_pc(8'h10);
        wait_addr = 9'h010; ir_ready = 1'b0; fetch_en = 1'b1;
        addr_q.push_back(8'h10); addr_q.push_back(8'h11);
        addr_q.push_back(8'h80); addr_q.push_back(8'h81);
        exp_q.push_back('{op: 8'hA5, arg: 8'h3C});
        exp_q.push_back('{op: 8'h5A, arg: 8'hC3});
        adv(1);
        fetch_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t3_wait_req", 32'(mem_req), 32'(1));
            chk("t3_wait_addr", 32'(mem_addr), 32'(8'h10));
            chk("t3_wait_ctrl", 32'(pc_ctrl), (k == 4) ? 32'(2'b10) : 32'(2'b00));
            adv(1);
        end
        wait_addr = 9'h100;
        adv(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(ir_valid), 32'(1));
            chk("t4_hold_op", 32'(ir_opcode), 32'(8'hA5));
            chk("t4_hold_arg", 32'(ir_operand), 32'(8'h3C));
            chk("t4_hold_req", 32'(mem_req), 32'(0));
            chk("t4_hold_ctrl", 32'(pc_ctrl), 32'(2'b00));
            adv(1);
        end
        ir_ready = 1'b1; br_take = 1'b1; br_target = 8'h80; fetch_en = 1'b1;
        @(negedge clk);
        chk("t5_br_ctrl", 32'(pc_ctrl), 32'(2'b01));
        chk("t5_br_load", 32'(pc_load), 32'(8'h80));
        adv(1);
        br_take = 1'b0; fetch_en = 1'b0;
        @(negedge clk);
        chk("t5_load_cleared", 32'(pc_load), 32'(0));
        chk("t5_fetch_at_target", 32'(mem_addr), 32'(8'h80));
        adv(3);
        @(negedge clk);
        chk("t5_idle_req", 32'(mem_req), 32'(0));
        adv(1);

        // PC wrap between opcode and operand, fetch_en dropped mid-F_OP
        set_pc(8'hFF);
        fetch_en = 1'b1;
        addr_q.push_back(8'hFF); addr_q.push_back(8'h00);
        exp_q.push_back('{op: 8'h11, arg: 8'h22});
        adv(1);
        fetch_en = 1'b0;
        @(negedge clk);
        chk("t6_op_addr", 32'(mem_addr), 32'(8'hFF));
        adv(1);
        @(negedge clk);
        chk("t6_arg_addr", 32'(mem_addr), 32'(8'h00));
        adv(2);
        @(negedge clk);
        chk("t6_idle_req", 32'(mem_req), 32'(0));
        chk("t6_idle_valid", 32'(ir_valid), 32'(0));
        adv(1);
        @(negedge clk);
        chk("t6_stays_idle", 32'(mem_req), 32'(0));

        chk("fetch_queue_drained", 32'(addr_q.size()), 32'(0));
        chk("instr_queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
